// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber-style parameters and loader FSM states
// Purpose: constants and types shared by the ciphertext loader and the decrypt stage.
// Ports: none (package).
package kyber_pkg;

  localparam int KYBER_Q = 17;  // coefficient modulus
  localparam int KYBER_N = 4;   // coefficients per polynomial
  localparam int KYBER_K = 2;   // module rank
  localparam int COEFF_W = 32;  // coefficient word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } ld_state_e;

endpackage

// File: rtl/mod_q_reduce.sv
// rtl/mod_q_reduce.sv - combinational signed-to-[0,Q-1] reducer
// Purpose: maps a signed coefficient onto its canonical residue modulo Q.
// Ports:
//   i_x : signed input coefficient
//   o_r : residue in 0..Q-1
module mod_q_reduce
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int W = COEFF_W
) (
  input  logic signed [W-1:0] i_x,
  output logic        [W-1:0] o_r
);

  localparam logic signed [W-1:0] QS = W'(Q);

  logic signed [W-1:0] w_rem;

  // Signed % keeps the dividend's sign, so a negative remainder is lifted by Q.
  assign w_rem = i_x % QS;
  assign o_r   = (w_rem < 0) ? W'(w_rem + QS) : W'(w_rem);

endmodule

// File: rtl/ciphertext_loader.sv
// rtl/ciphertext_loader.sv - framed ciphertext loader with key store and decrypt handshake
// Purpose: collects a 16-word ciphertext frame into a shadow buffer, commits it
// atomically on a correctly terminated frame and holds it until the decrypt
// stage acknowledges; also holds the secret key written over a simple strobe.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last : ciphertext word stream
//   sk_we/sk_addr/sk_data         : secret key write port
//   ciphertext, secret_key        : committed frame and stored key
//   dec_enable/dec_ack            : frame-pending flag and its consume strobe
//   err_len                       : one-cycle frame-length error pulse
module ciphertext_loader
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int N = KYBER_N,
  parameter int K = KYBER_K
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_data,
  input  logic                      in_last,
  input  logic                      sk_we,
  input  logic [2:0]                sk_addr,
  input  logic signed [COEFF_W-1:0] sk_data,
  output logic signed [COEFF_W-1:0] ciphertext [1:0][K-1:0][N-1:0],
  output logic signed [COEFF_W-1:0] secret_key [K-1:0][N-1:0],
  output logic                      dec_enable,
  input  logic                      dec_ack,
  output logic                      err_len
);

  localparam int FRAME_LEN = 2 * K * N;

  ld_state_e r_state;
  ld_state_e w_state_nxt;

  logic [3:0]                r_k;
  logic signed [COEFF_W-1:0] r_shadow     [1:0][K-1:0][N-1:0];
  logic signed [COEFF_W-1:0] w_shadow_nxt [1:0][K-1:0][N-1:0];
  logic signed [COEFF_W-1:0] r_ciphertext [1:0][K-1:0][N-1:0];
  logic signed [COEFF_W-1:0] r_sk         [K-1:0][N-1:0];
  logic                      r_dec;
  logic                      r_err;

  logic [COEFF_W-1:0] w_red;
  logic               w_xfer;
  logic               w_at_end;
  logic               w_commit;
  logic               w_err;

  mod_q_reduce #(.Q(Q), .W(COEFF_W)) u_reduce (
    .i_x (in_data),
    .o_r (w_red)
  );

  assign w_xfer   = in_valid & in_ready;
  assign w_at_end = (r_k == 4'(FRAME_LEN - 1));
  assign w_commit = w_xfer & in_last & w_at_end;
  // in_last must coincide exactly with the final word; either mismatch is an error.
  assign w_err    = w_xfer & (in_last ^ w_at_end);

  // Shadow image including the word being accepted, so the commit edge can
  // copy a complete frame in one step.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[r_k[3]][r_k[2]][r_k[1:0]] = w_red;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (w_xfer) begin
          if (w_err)         w_state_nxt = ST_IDLE;
          else if (w_commit) w_state_nxt = ST_HOLD;
          else               w_state_nxt = ST_LOAD;
        end
      end
      ST_HOLD: if (dec_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: in_ready = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_dec <= 1'b0;
      r_err <= 1'b0;
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < K; b++)
          for (int i = 0; i < N; i++) begin
            r_shadow[a][b][i]     <= '0;
            r_ciphertext[a][b][i] <= '0;
          end
      for (int b = 0; b < K; b++)
        for (int i = 0; i < N; i++)
          r_sk[b][i] <= '0;
    end else begin
      r_err <= w_err;
      if (w_xfer) begin
        if (w_err) begin
          r_k <= '0;
          for (int a = 0; a < 2; a++)
            for (int b = 0; b < K; b++)
              for (int i = 0; i < N; i++)
                r_shadow[a][b][i] <= '0;
        end else if (w_commit) begin
          r_k          <= '0;
          r_ciphertext <= w_shadow_nxt;
        end else begin
          r_k <= r_k + 4'd1;
          r_shadow[r_k[3]][r_k[2]][r_k[1:0]] <= w_red;
        end
      end
      if (w_commit)                          r_dec <= 1'b1;
      else if (r_state == ST_HOLD && dec_ack) r_dec <= 1'b0;
      // The key is frozen while a frame is pending so decrypt sees a stable pair.
      if (sk_we && r_state != ST_HOLD)
        r_sk[sk_addr[2]][sk_addr[1:0]] <= sk_data;
    end
  end

  assign ciphertext = r_ciphertext;
  assign secret_key = r_sk;
  assign dec_enable = r_dec;
  assign err_len    = r_err;

endmodule

// File: tb/tb_ciphertext_loader.sv
// tb/tb_ciphertext_loader.sv - self-checking bench for ciphertext_loader
module tb_ciphertext_loader;

  localparam int Q = 17;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_last;
  logic               sk_we;
  logic [2:0]         sk_addr;
  logic signed [31:0] sk_data;
  logic signed [31:0] ciphertext [1:0][1:0][3:0];
  logic signed [31:0] secret_key [1:0][3:0];
  logic               dec_enable;
  logic               dec_ack;
  logic               err_len;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: words of the frame in progress, committed frame, key.
  int m_buf[$];
  int m_ct[16];
  int m_sk[8];
  bit m_hold;
  bit m_dec;
  int w_vals[16];

  ciphertext_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sk_we      (sk_we),
    .sk_addr    (sk_addr),
    .sk_data    (sk_data),
    .ciphertext (ciphertext),
    .secret_key (secret_key),
    .dec_enable (dec_enable),
    .dec_ack    (dec_ack),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  function automatic int red(int x);
    longint r;
    r = longint'(x) % longint'(Q);
    return int'((r + Q) % Q);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data();
    for (int j = 0; j < 16; j++)
      chk($sformatf("ct[%0d]", j), ciphertext[j / 8][(j / 4) % 2][j % 4], m_ct[j]);
    for (int j = 0; j < 8; j++)
      chk($sformatf("sk[%0d]", j), secret_key[j / 4][j % 4], m_sk[j]);
  endtask

  // One clock cycle of stimulus, then model update and control-output checks.
  task automatic step(bit v, int x, bit last, bit we, int a, int d, bit ack);
    bit hold0;
    bit exp_err;
    in_valid = v; in_data = x; in_last = last;
    sk_we = we; sk_addr = 3'(a); sk_data = d; dec_ack = ack;
    @(posedge clk); #1;
    hold0   = m_hold;
    exp_err = 1'b0;
    if (we && !hold0) m_sk[a] = d;
    if (hold0 && ack) begin m_hold = 1'b0; m_dec = 1'b0; end
    if (v && !hold0) begin
      m_buf.push_back(red(x));
      if (last && m_buf.size() == 16) begin
        for (int j = 0; j < 16; j++) m_ct[j] = m_buf[j];
        m_buf.delete();
        m_hold = 1'b1;
        m_dec  = 1'b1;
      end else if (last || m_buf.size() == 16) begin
        m_buf.delete();
        exp_err = 1'b1;
      end
    end
    chk("err_len", err_len, exp_err);
    chk("dec_enable", dec_enable, m_dec);
    chk("in_ready", in_ready, !m_hold);
    in_valid = 1'b0; in_last = 1'b0; sk_we = 1'b0; dec_ack = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_words(int n, int last_at, bit gaps, bit rnd_sk);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 3 == 0)) idle(1);
      step(1, w_vals[i], i == last_at, rnd_sk && ($urandom % 4 == 0),
           int'($urandom % 8), int'($urandom), 0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) w_vals[i] = int'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_buf.delete();
    for (int j = 0; j < 16; j++) m_ct[j] = 0;
    for (int j = 0; j < 8; j++) m_sk[j] = 0;
    m_hold = 1'b0;
    m_dec  = 1'b0;
    #2;
    chk("rst_err_len", err_len, 0);
    chk("rst_dec_enable", dec_enable, 0);
    check_data();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    in_valid = 0; in_data = 0; in_last = 0;
    sk_we = 0; sk_addr = 0; sk_data = 0; dec_ack = 0;
    @(posedge clk); #1;
    do_reset();

    // Normal frame: key all 1, words 0..15 back-to-back.
    for (int a = 0; a < 8; a++) step(0, 0, 0, 1, a, 1, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, k, k == 15, 0, 0, 0, 0);
      if (k == 7) check_data();
    end
    check_data();
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++)
          chk("ct_lin", ciphertext[a][b][i], 8 * a + 4 * b + i);
    for (int j = 0; j < 8; j++) chk("sk_one", secret_key[j / 4][j % 4], 1);

    // Backpressure in HOLD with key writes attempted.
    for (int c = 0; c < 10; c++) step(1, int'($urandom), 0, 1, 0, 5, 0);
    chk("hold_sk00", secret_key[0][0], 1);
    check_data();
    step(0, 0, 0, 0, 0, 0, 1);

    // dec_ack outside HOLD has no effect.
    step(0, 0, 0, 0, 0, 0, 1);

    // Reduction of boundary values.
    fill_random();
    w_vals[0] = -1; w_vals[1] = 35; w_vals[2] = 17; w_vals[3] = -18;
    send_words(16, 15, 0, 0);
    check_data();
    chk("red_m1", ciphertext[0][0][0], 16);
    chk("red_35", ciphertext[0][0][1], 1);
    chk("red_17", ciphertext[0][0][2], 0);
    chk("red_m18", ciphertext[0][0][3], 16);
    step(0, 0, 0, 0, 0, 0, 1);

    // Early in_last at k=7, then a clean frame.
    fill_random();
    send_words(8, 7, 0, 0);
    idle(1);
    check_data();
    fill_random();
    send_words(16, 15, 0, 0);
    check_data();
    step(0, 0, 0, 0, 0, 0, 1);

    // Missing in_last on word 15, then a clean frame.
    fill_random();
    send_words(16, 99, 0, 0);
    idle(1);
    check_data();
    fill_random();
    send_words(16, 15, 1, 1);
    check_data();
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized frames with gaps and key writes.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_words(16, 15, 1, 1);
      idle(int'($urandom % 3));
      check_data();
      step(0, 0, 0, 0, 0, 0, 1);
    end

    // Reset mid-LOAD after 9 words, then a full frame.
    fill_random();
    send_words(9, 99, 0, 0);
    do_reset();
    fill_random();
    send_words(16, 15, 0, 0);
    check_data();
    step(0, 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
